// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, state codes, mux/ALU encodings and the control vector
// for the multicycle MIPS control unit.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_LUI   = 2'b11;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef struct packed {
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_ctr;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
   } ctrl_t;

   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_ADDI, OP_J: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// State to control-vector decode. Everything is Moore except IRWrite/PCWrite
// in FETCH, which follow the memory-done term.
module ctrl_out_decode
   import mips_ctrl_pkg::*;
(
   input  logic [3:0] state,
   input  logic       mem_done,
   input  logic       imm_lui,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_ctr   = ALU_ADD;
            ctrl.pc_src    = PC_ALU;
            ctrl.ir_write  = mem_done;
            ctrl.pc_write  = mem_done;
         end
         S_DECODE: begin
            // branch target computed speculatively into ALUOut
            ctrl.alu_src_b = SRCB_IMMSH2;
            ctrl.alu_ctr   = ALU_ADD;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_ctr   = ALU_ADD;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_ctr   = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_IEXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_ctr   = imm_lui ? ALU_LUI : ALU_ADD;
         end
         S_IWB: begin
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_B;
            ctrl.alu_ctr       = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_src        = PC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_JUMP;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences each instruction over 3-5 states,
// optionally stretching memory states until mem_ready.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 0,
   parameter int ALUCTR_W = 2
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          op,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                RegDst,
   output logic                RegWrite,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [ALUCTR_W-1:0] ALUctr,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                MemtoReg,
   output logic                IorD,
   output logic                IRWrite,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic [1:0]          PCSrc,
   output logic                illegal_op,
   output logic [3:0]          state
);

   state_t     state_q, state_n;
   logic [5:0] op_q;
   logic       mem_done;
   ctrl_t      ctrl_raw, ctrl;

   // The branch decision is taken in the datapath (PCWriteCond & zero);
   // the flag only passes through this block's interface.
   logic unused_zero;
   assign unused_zero = zero;

   assign mem_done = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

   always_comb begin
      state_n = S_FETCH;
      case (state_q)
         S_FETCH:  state_n = mem_done ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:    state_n = S_MEMADR;
               OP_R:            state_n = S_EXEC;
               OP_BEQ:          state_n = S_BRANCH;
               OP_ADDI, OP_LUI: state_n = S_IEXEC;
               OP_J:            state_n = S_JUMP;
               default:         state_n = S_FETCH;
            endcase
         end
         S_MEMADR: state_n = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_n = mem_done ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_n = mem_done ? S_FETCH : S_MEMWR;
         S_EXEC:   state_n = S_ALUWB;
         S_IEXEC:  state_n = S_IWB;
         default:  state_n = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_n;
         if (state_q == S_DECODE)
            op_q <= op;
      end
   end

   ctrl_out_decode u_dec (
      .state    (state_q),
      .mem_done (mem_done),
      .imm_lui  (op_q == OP_LUI),
      .ctrl     (ctrl_raw)
   );

   // Reset forces every strobe and mux select low, so an interrupted
   // instruction cannot finish a write during the reset cycle.
   assign ctrl = reset ? '0 : ctrl_raw;

   assign RegDst      = ctrl.reg_dst;
   assign RegWrite    = ctrl.reg_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign IorD        = ctrl.i_or_d;
   assign IRWrite     = ctrl.ir_write;
   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign PCSrc       = ctrl.pc_src;

   always_comb begin
      ALUctr      = '0;
      ALUctr[1:0] = ctrl.alu_ctr;
   end

   assign illegal_op = !reset && (state_q == S_DECODE) && !op_legal(op);
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed sequences, a stimulus table, and a
// randomized run against an instruction-route reference model.
module tb_multicycle_control;
   import mips_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst0, rst1, zero, mem_ready;
   logic [5:0] op0, op1;

   logic       RegDst0, RegWrite0, ALUSrcA0, MemRead0, MemWrite0, MemtoReg0, IorD0;
   logic       IRWrite0, PCWrite0, PCWriteCond0, ill0;
   logic [1:0] ALUSrcB0, ALUctr0, PCSrc0;
   logic [3:0] state0;
   logic       RegDst1, RegWrite1, ALUSrcA1, MemRead1, MemWrite1, MemtoReg1, IorD1;
   logic       IRWrite1, PCWrite1, PCWriteCond1, ill1;
   logic [1:0] ALUSrcB1, PCSrc1;
   logic [2:0] ALUctr1;
   logic [3:0] state1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_WAIT(0), .ALUCTR_W(2)) dut0 (
      .clk(clk), .reset(rst0), .op(op0), .zero(zero), .mem_ready(mem_ready),
      .RegDst(RegDst0), .RegWrite(RegWrite0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
      .ALUctr(ALUctr0), .MemRead(MemRead0), .MemWrite(MemWrite0), .MemtoReg(MemtoReg0),
      .IorD(IorD0), .IRWrite(IRWrite0), .PCWrite(PCWrite0), .PCWriteCond(PCWriteCond0),
      .PCSrc(PCSrc0), .illegal_op(ill0), .state(state0)
   );

   multicycle_control #(.MEM_WAIT(1), .ALUCTR_W(3)) dut1 (
      .clk(clk), .reset(rst1), .op(op1), .zero(zero), .mem_ready(mem_ready),
      .RegDst(RegDst1), .RegWrite(RegWrite1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1),
      .ALUctr(ALUctr1), .MemRead(MemRead1), .MemWrite(MemWrite1), .MemtoReg(MemtoReg1),
      .IorD(IorD1), .IRWrite(IRWrite1), .PCWrite(PCWrite1), .PCWriteCond(PCWriteCond1),
      .PCSrc(PCSrc1), .illegal_op(ill1), .state(state1)
   );

   logic [16:0] ctl0, ctl1;
   assign ctl0 = {RegDst0, RegWrite0, ALUSrcA0, ALUSrcB0, ALUctr0, MemRead0, MemWrite0,
                  MemtoReg0, IorD0, IRWrite0, PCWrite0, PCWriteCond0, PCSrc0, ill0};
   assign ctl1 = {RegDst1, RegWrite1, ALUSrcA1, ALUSrcB1, ALUctr1[1:0], MemRead1, MemWrite1,
                  MemtoReg1, IorD1, IRWrite1, PCWrite1, PCWriteCond1, PCSrc1, ill1};

   // one bit per field of the packed control word above
   localparam logic [16:0] B_RD  = 17'h10000, B_RW  = 17'h08000, B_SA  = 17'h04000;
   localparam logic [16:0] B_SB1 = 17'h02000, B_SB0 = 17'h01000, B_AC1 = 17'h00800;
   localparam logic [16:0] B_AC0 = 17'h00400, B_MR  = 17'h00200, B_MW  = 17'h00100;
   localparam logic [16:0] B_M2R = 17'h00080, B_IOD = 17'h00040, B_IRW = 17'h00020;
   localparam logic [16:0] B_PCW = 17'h00010, B_PCC = 17'h00008, B_PS1 = 17'h00004;
   localparam logic [16:0] B_PS0 = 17'h00002, B_ILL = 17'h00001;

   localparam logic [16:0] K_FETCH = B_MR | B_SB0;
   localparam logic [16:0] K_FD    = K_FETCH | B_IRW | B_PCW;
   localparam logic [16:0] K_DEC   = B_SB1 | B_SB0;
   localparam logic [16:0] K_MADR  = B_SA | B_SB1;
   localparam logic [16:0] K_MRD   = B_MR | B_IOD;
   localparam logic [16:0] K_MWB   = B_RW | B_M2R;
   localparam logic [16:0] K_MWR   = B_MW | B_IOD;
   localparam logic [16:0] K_EXEC  = B_SA | B_AC1;
   localparam logic [16:0] K_AWB   = B_RD | B_RW;
   localparam logic [16:0] K_BR    = B_SA | B_AC0 | B_PCC | B_PS0;
   localparam logic [16:0] K_JMP   = B_PCW | B_PS1;
   localparam logic [16:0] K_IEX   = B_SA | B_SB1;
   localparam logic [16:0] K_ILUI  = K_IEX | B_AC1 | B_AC0;
   localparam logic [16:0] K_IWB   = B_RW;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic legal(input logic [5:0] o);
      case (o)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_ADDI, OP_J: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // States visited after DECODE, one nibble each, lowest first, ending in FETCH.
   function automatic logic [19:0] route(input logic [5:0] o);
      case (o)
         OP_LW:           return 20'h00432;
         OP_SW:           return 20'h00052;
         OP_R:            return 20'h00076;
         OP_BEQ:          return 20'h00008;
         OP_J:            return 20'h00009;
         OP_ADDI, OP_LUI: return 20'h000BA;
         default:         return 20'h00000;
      endcase
   endfunction

   function automatic logic [16:0] ctl_of(input logic [3:0] s, input logic lui_q,
                                          input logic rdy, input logic [5:0] o);
      case (s)
         4'd0:    return rdy ? K_FD : K_FETCH;
         4'd1:    return legal(o) ? K_DEC : (K_DEC | B_ILL);
         4'd2:    return K_MADR;
         4'd3:    return K_MRD;
         4'd4:    return K_MWB;
         4'd5:    return K_MWR;
         4'd6:    return K_EXEC;
         4'd7:    return K_AWB;
         4'd8:    return K_BR;
         4'd9:    return K_JMP;
         4'd10:   return lui_q ? K_ILUI : K_IEX;
         4'd11:   return K_IWB;
         default: return 17'h0;
      endcase
   endfunction

   logic [19:0] rt [2];
   int          ix [2];
   logic        lui_m [2];

   function automatic logic [3:0] mst(input int i);
      return rt[i][4*ix[i] +: 4];
   endfunction

   task automatic step(input int i, input logic r, input logic rdy, input logic [5:0] o);
      logic [3:0] s;
      s = mst(i);
      if (r) begin
         rt[i] = '0; ix[i] = 0;
      end else if ((s == 4'd0 || s == 4'd3 || s == 4'd5) && !rdy) begin
         // memory still busy: hold
      end else if (s == 4'd0) begin
         rt[i] = 20'h00001; ix[i] = 0;
      end else if (s == 4'd1) begin
         rt[i] = route(o); ix[i] = 0; lui_m[i] = (o == OP_LUI);
      end else begin
         ix[i]++;
      end
   endtask

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 7))
         0: return OP_R;
         1: return OP_LW;
         2: return OP_SW;
         3: return OP_BEQ;
         4: return OP_LUI;
         5: return OP_ADDI;
         6: return OP_J;
         default: return 6'($urandom);
      endcase
   endfunction

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        rdy;
      logic        z;
      logic [3:0]  st;
      logic [16:0] ctl;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic r, input logic [5:0] o, input logic rd, input logic z,
                      input logic [3:0] s, input logic [16:0] c);
      vec_t v;
      v.rst = r; v.op = o; v.rdy = rd; v.z = z; v.st = s; v.ctl = c;
      tbl.push_back(v);
   endtask

   logic [3:0] seq_a [6];

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; op0 = OP_LW; op1 = OP_LW; zero = 1'b0; mem_ready = 1'b0;

      // dut0 (no wait states): two reset cycles, then lw ignoring mem_ready=0
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         chk("reset state", 32'(state0), 32'd0);
         chk("reset ctl", 32'(ctl0), 32'd0);
      end
      seq_a = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         rst0 = 1'b0;
         #1;
         chk($sformatf("lw nowait state c%0d", c), 32'(state0), 32'(seq_a[c]));
         chk($sformatf("lw nowait ctl c%0d", c), 32'(ctl0), 32'(ctl_of(seq_a[c], 1'b0, 1'b1, OP_LW)));
      end
      rst0 = 1'b1;

      // dut1 (memory handshake) directed table
      add(1, OP_LW,   1, 0, 4'd0,  17'h0);
      add(0, OP_SW,   1, 0, 4'd0,  K_FD);
      add(0, OP_SW,   0, 0, 4'd1,  K_DEC);
      add(0, OP_SW,   0, 0, 4'd2,  K_MADR);
      add(0, OP_SW,   0, 0, 4'd5,  K_MWR);
      add(0, OP_SW,   0, 0, 4'd5,  K_MWR);
      add(0, OP_SW,   0, 0, 4'd5,  K_MWR);
      add(0, OP_SW,   1, 0, 4'd5,  K_MWR);
      add(0, OP_BEQ,  0, 1, 4'd0,  K_FETCH);
      add(0, OP_BEQ,  1, 1, 4'd0,  K_FD);
      add(0, OP_BEQ,  1, 1, 4'd1,  K_DEC);
      add(0, OP_BEQ,  1, 1, 4'd8,  K_BR);
      add(0, OP_BEQ,  1, 0, 4'd0,  K_FD);
      add(0, OP_BEQ,  1, 0, 4'd1,  K_DEC);
      add(0, OP_BEQ,  1, 0, 4'd8,  K_BR);
      add(0, OP_LUI,  1, 0, 4'd0,  K_FD);
      add(0, OP_LUI,  1, 0, 4'd1,  K_DEC);
      add(0, OP_LUI,  1, 0, 4'd10, K_ILUI);
      add(0, OP_LUI,  1, 0, 4'd11, K_IWB);
      add(0, OP_ADDI, 1, 0, 4'd0,  K_FD);
      add(0, OP_ADDI, 1, 0, 4'd1,  K_DEC);
      add(0, OP_ADDI, 1, 0, 4'd10, K_IEX);
      add(0, OP_ADDI, 1, 0, 4'd11, K_IWB);
      add(0, 6'h3F,   1, 0, 4'd0,  K_FD);
      add(0, 6'h3F,   1, 0, 4'd1,  K_DEC | B_ILL);
      add(0, OP_LW,   1, 0, 4'd0,  K_FD);
      add(0, OP_LW,   1, 0, 4'd1,  K_DEC);
      add(0, OP_LW,   1, 0, 4'd2,  K_MADR);
      add(0, OP_LW,   0, 0, 4'd3,  K_MRD);
      add(1, OP_LW,   0, 0, 4'd3,  17'h0);
      add(0, OP_R,    1, 0, 4'd0,  K_FD);
      add(0, OP_R,    1, 0, 4'd1,  K_DEC);
      add(0, OP_R,    1, 0, 4'd6,  K_EXEC);
      add(0, OP_R,    1, 0, 4'd7,  K_AWB);
      add(0, OP_J,    1, 0, 4'd0,  K_FD);
      add(0, OP_J,    1, 0, 4'd1,  K_DEC);
      add(0, OP_J,    1, 0, 4'd9,  K_JMP);
      add(0, OP_J,    0, 0, 4'd0,  K_FETCH);
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst1 = tbl[i].rst; op1 = tbl[i].op; mem_ready = tbl[i].rdy; zero = tbl[i].z;
         #1;
         chk($sformatf("tbl%0d state", i), 32'(state1), 32'(tbl[i].st));
         chk($sformatf("tbl%0d ctl", i), 32'(ctl1), 32'(tbl[i].ctl));
      end

      // randomized run of both instances against the route model
      @(negedge clk);
      rst0 = 1'b1; rst1 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rt[i] = '0; ix[i] = 0; lui_m[i] = 1'b0;
      end
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst0 = ($urandom_range(0, 39) == 0);
         rst1 = ($urandom_range(0, 39) == 0);
         zero = 1'($urandom);
         mem_ready = ($urandom_range(0, 2) != 0);
         if (mst(0) == 4'd0) op0 = pick_op();
         if (mst(1) == 4'd0) op1 = pick_op();
         #1;
         chk($sformatf("rnd%0d dut0 state", c), 32'(state0), 32'(mst(0)));
         chk($sformatf("rnd%0d dut0 ctl", c), 32'(ctl0),
             rst0 ? 32'd0 : 32'(ctl_of(mst(0), lui_m[0], 1'b1, op0)));
         chk($sformatf("rnd%0d dut1 state", c), 32'(state1), 32'(mst(1)));
         chk($sformatf("rnd%0d dut1 ctl", c), 32'(ctl1),
             rst1 ? 32'd0 : 32'(ctl_of(mst(1), lui_m[1], mem_ready, op1)));
         chk($sformatf("rnd%0d dut1 aluctr msb", c), 32'(ALUctr1[2]), 32'd0);
         step(0, rst0, 1'b1, op0);
         step(1, rst1, mem_ready, op1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
